tagger_cfg_seq: RTL and testbench
=================================

// Module: tagger_cfg_seq
// PURPOSE
// RegBus initiator that programs the tagger's partition configuration registers from a parallel table.
// - Sits between an SoC control unit (or boot FSM) and the tagger cfg port.
// - On start it writes all address, PATID and mode registers, then writes Commit.
// - It can optionally read each register back to verify it.
// PARAMETERS
// MAXPARTITION  8      number of partitions; must match the tagger instance
// PATID_WIDTH   4      PATID field width (AXI_USER_ID_MSB-AXI_USER_ID_LSB+1)
// READBACK      1'b0   1: read each non-commit register after writing it and compare
// reg_req_t     logic  RegBus request type (32b addr, 32b data, 4b strb)
// reg_rsp_t     logic  RegBus response type
// PORTS
// clk_i        in   1                           clock
// rst_ni       in   1                           async reset, active-low
// start_i      in   1                           start a programming sequence (honoured in IDLE only)
// addr_cfg_i   in   MAXPARTITION x 32           per-partition address word, already >>2 (TOR top / NAPOT encoded)
// patid_cfg_i  in   MAXPARTITION x PATID_WIDTH  per-partition PATID
// mode_cfg_i   in   MAXPARTITION x 2            per-partition mode: 00 off, 01 TOR, 11 NAPOT
// busy_o       out  1                           sequence in progress
// done_o       out  1                           one-cycle pulse: commit accepted without error
// error_o      out  1                           sticky: slave error or readback mismatch; cleared by next start
// err_idx_o    out  8                           index of the failing transaction in the write order
// reg_req_o    out  reg_req_t                   RegBus request (addr/write/wdata/wstrb/valid)
// reg_rsp_i    in   reg_rsp_t                   RegBus response (rdata/error/ready)
// BEHAVIOUR
// - Reset values: all outputs 0, reg_req_o.valid=0, FSM in IDLE.
// - Derived sizes:
//   - PPW = 32/PATID_WIDTH PATIDs per word.
//   - NP = ceil(MAXPARTITION/PPW) PATID words.
//   - NC = ceil(MAXPARTITION/16) mode words.
// - Register map:
//   - Commit at 0x00.
//   - Addr k at 0x04+4k.
//   - PATID word j at 0x04+4*MAXPARTITION+4j.
//   - Mode word j follows the PATID words.
//   - For MAXPARTITION=8: Addr 0x04..0x20, PATID 0x24, Conf 0x28.
// - Packing:
//   - PATID k sits at bits [k%PPW*PATID_WIDTH +: PATID_WIDTH] of word k/PPW.
//   - Mode k sits at [2*(k%16) +: 2] of word k/16.
//   - Unused bits are 0.
// - Write order and index: Addr0..AddrN-1, PATID words, mode words, then Commit with data 1.
// - Total transactions T = MAXPARTITION+NP+NC+1 (11 at defaults); idx counts 0..T-1.
// - All inputs are snapshotted into internal regs on the cycle start_i is accepted. Later input changes are ignored.
// - FSM states:
//   - IDLE: start_i=1 -> snapshot, clear error_o, busy_o=1, idx=0 -> WR.
//   - WR: valid=1, write=1, wstrb=4'hF.
//     - On ready & !error: READBACK and idx<T-1 -> RD; idx=T-1 -> DONE; else idx++ and stay in WR.
//   - RD: valid=1, write=0, same addr.
//     - On ready: mismatch or error -> ERR; else idx++ -> WR.
//   - DONE: done_o=1 for one cycle, busy_o=0 -> IDLE.
//   - ERR: error_o=1, err_idx_o=idx, busy_o=0 -> IDLE. No Commit is issued.
// - Handshake:
//   - addr, write, wdata and wstrb are stable while valid=1; valid stays high until ready=1.
//   - valid is registered and rises the cycle after start is accepted.
//   - A transfer completes in the cycle where valid & ready.
//   - The next request is presented the following cycle, so back-to-back issue is one per cycle with ready held at 1.
// - Latency: with ready=1, READBACK=0 and start accepted at cycle 0, valid is high in cycles 1..T and done_o pulses in cycle T+1.
// - A reg_rsp_i.error on any write, including Commit, goes to ERR on that handshake cycle.
// - start_i while busy_o=1 is ignored. start_i in the DONE or ERR cycle is ignored.
// - Async reset mid-sequence drops valid immediately, returns to IDLE and clears error_o.
// TESTING
// - NAPOT:
//   - Stimulus: addr0..3 = 0x09FFFFFF, 0x10FFFFFF, 0x19FFFFFF, 0x21FFFFFF; PATIDs 0..7; modes 11 for p0-3, 00 for p4-7; ready=1.
//   - Expect writes 0x04..0x10 with these values, 0x14..0x20 = 0, 0x24 = 0x76543210, 0x28 = 0x000000FF, 0x00 = 1.
//   - Expect done_o in cycle 12.
// - TOR:
//   - Stimulus: addr0..3 = 0x08000000, 0x10000000, 0x18000000, 0x20000000; PATIDs 7,6,5,4,3,2,1,0; modes 01 for p0-3.
//   - Expect 0x24 = 0x01234567 and 0x28 = 0x00000055.
// - Backpressure: hold ready=0 for 5 cycles on the PATID write.
//   - Expect valid, addr and wdata stable throughout, no skipped or duplicated transaction, and done_o 5 cycles later.
// - Slave error: assert rsp.error on the idx 9 write.
//   - Expect error_o=1, err_idx_o=9, no Commit write, and error_o cleared on the next start.
// - READBACK=1 with a slave model that corrupts Addr2 rdata.
//   - Expect write/read pairs in order, ERR with err_idx_o=2, and no Commit.
// - Robustness: pulse start_i while busy and change the inputs mid-sequence, then assert rst_ni low mid-sequence.
//   - Expect no restart and values taken from the snapshot; after reset, valid=0, busy_o=0 and a fresh start completes.

Source files
------------

// File: rtl/tagger_cfg_seq.sv
// ---------------------------------------------------------------------------
// tagger_cfg_seq
//   RegBus initiator that programs the tagger's partition configuration
//   registers from a parallel table. On start it writes every Addr register,
//   the packed PATID words and the packed mode words, then writes Commit = 1.
//   With READBACK=1 each non-commit register is read back right after it is
//   written, and the value read is compared with the value written.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous reset, active-low
//   start_i      start a programming sequence (honoured in IDLE only)
//   addr_cfg_i   partition k address word at [32*k +: 32] (already >>2)
//   patid_cfg_i  partition k PATID at [PATID_WIDTH*k +: PATID_WIDTH]
//   mode_cfg_i   partition k mode at [2*k +: 2] (00 off, 01 TOR, 11 NAPOT)
//   busy_o       sequence in progress
//   done_o       one-cycle pulse: Commit accepted without error
//   error_o      sticky: slave error or readback mismatch; cleared by start
//   err_idx_o    write-order index of the failing transaction
//   reg_req_o    RegBus request  {addr[31:0], write, wdata[31:0], wstrb[3:0], valid}
//   reg_rsp_i    RegBus response {rdata[31:0], error, ready}
// ---------------------------------------------------------------------------
module tagger_cfg_seq #(
  parameter int unsigned MAXPARTITION = 8,
  parameter int unsigned PATID_WIDTH  = 4,
  parameter bit          READBACK     = 1'b0
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                start_i,
  input  logic [MAXPARTITION*32-1:0]          addr_cfg_i,
  input  logic [MAXPARTITION*PATID_WIDTH-1:0] patid_cfg_i,
  input  logic [MAXPARTITION*2-1:0]           mode_cfg_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                error_o,
  output logic [7:0]                          err_idx_o,
  output logic [69:0]                         reg_req_o,
  input  logic [33:0]                         reg_rsp_i
);

  localparam int unsigned PPW  = 32 / PATID_WIDTH;
  localparam int unsigned NP   = (MAXPARTITION + PPW - 1) / PPW;
  localparam int unsigned NC   = (MAXPARTITION + 15) / 16;
  localparam int unsigned T    = MAXPARTITION + NP + NC + 1;
  localparam logic [7:0]  LAST = 8'(T - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DONE, S_ERR} state_t;

  state_t          state;
  logic [7:0]      idx;
  logic [7:0]      idx_nxt;
  logic [T*32-1:0] tab_in;
  logic [T*32-1:0] tab_snap;
  logic [31:0]     snap_nxt;

  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [3:0]      req_wstrb;
  logic            req_write;
  logic            req_valid;

  logic [31:0]     rsp_rdata;
  logic            rsp_error;
  logic            rsp_ready;

  assign {rsp_rdata, rsp_error, rsp_ready} = reg_rsp_i;
  assign reg_req_o = {req_addr, req_write, req_wdata, req_wstrb, req_valid};

  // Register address in write order: Addr/PATID/mode registers are contiguous
  // from 0x04, and the final transaction is Commit at 0x00.
  function automatic logic [31:0] reg_addr(input logic [7:0] i);
    if (i == LAST) return 32'h0;
    return 32'd4 + {22'd0, i, 2'b00};
  endfunction

  // Whole write table laid out in transaction order, one 32-bit word each.
  always_comb begin
    tab_in = '0;
    for (int k = 0; k < MAXPARTITION; k++) begin
      tab_in[k*32 +: 32] = addr_cfg_i[k*32 +: 32];
      tab_in[(MAXPARTITION + k/PPW)*32 + (k%PPW)*PATID_WIDTH +: PATID_WIDTH] =
        patid_cfg_i[k*PATID_WIDTH +: PATID_WIDTH];
      tab_in[(MAXPARTITION + NP + k/16)*32 + 2*(k%16) +: 2] = mode_cfg_i[2*k +: 2];
    end
    tab_in[(T-1)*32 +: 32] = 32'd1;
  end

  assign idx_nxt = idx + 8'd1;

  always_comb begin
    snap_nxt = '0;
    for (int i = 0; i < T; i++)
      if (idx_nxt == 8'(i)) snap_nxt = tab_snap[i*32 +: 32];
  end

  // Snapshot is pure data: loaded once per accepted start, never reset.
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && start_i) tab_snap <= tab_in;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      idx       <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      error_o   <= 1'b0;
      err_idx_o <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_write <= 1'b0;
      req_valid <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            state     <= S_WR;
            idx       <= '0;
            busy_o    <= 1'b1;
            error_o   <= 1'b0;
            err_idx_o <= '0;
            // The snapshot is being loaded this cycle, so take word 0 from the inputs.
            req_addr  <= reg_addr(8'd0);
            req_wdata <= tab_in[31:0];
            req_wstrb <= 4'hF;
            req_write <= 1'b1;
            req_valid <= 1'b1;
          end
        end
        S_WR: begin
          if (rsp_ready) begin
            if (rsp_error) begin
              state     <= S_ERR;
              error_o   <= 1'b1;
              err_idx_o <= idx;
              busy_o    <= 1'b0;
              req_valid <= 1'b0;
            end else if (idx == LAST) begin
              state     <= S_DONE;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
              req_valid <= 1'b0;
            end else if (READBACK) begin
              // Same address; wdata is kept as the reference for the compare.
              state     <= S_RD;
              req_write <= 1'b0;
              req_wstrb <= 4'h0;
            end else begin
              idx       <= idx_nxt;
              req_addr  <= reg_addr(idx_nxt);
              req_wdata <= snap_nxt;
            end
          end
        end
        S_RD: begin
          if (rsp_ready) begin
            if (rsp_error || (rsp_rdata != req_wdata)) begin
              state     <= S_ERR;
              error_o   <= 1'b1;
              err_idx_o <= idx;
              busy_o    <= 1'b0;
              req_valid <= 1'b0;
            end else begin
              state     <= S_WR;
              idx       <= idx_nxt;
              req_addr  <= reg_addr(idx_nxt);
              req_wdata <= snap_nxt;
              req_wstrb <= 4'hF;
              req_write <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tagger_cfg_seq.sv
module tb_tagger_cfg_seq;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start = 1'b0;
  logic         sel = 1'b0;
  logic [255:0] addr_cfg = '0;
  logic [31:0]  patid_cfg = '0;
  logic [15:0]  mode_cfg = '0;
  logic         rsp_ready = 1'b1;
  logic         rsp_err = 1'b0;
  logic [31:0]  rsp_rdata = '0;
  logic [33:0]  rsp;

  logic         start0, start1;
  logic         busy0, done0, error0, busy1, done1, error1;
  logic [7:0]   err_idx0, err_idx1;
  logic [69:0]  req0, req1, req;

  logic         v_busy, v_done, v_error, v_valid, v_write;
  logic [7:0]   v_err_idx;
  logic [31:0]  v_addr, v_wdata;
  logic [3:0]   v_wstrb;

  int tests = 0;
  int fails = 0;
  int done_cyc, err_cyc;
  logic err_at1;
  vec_t log_q[$];
  vec_t exp_q[$];
  logic [31:0] mem [16];

  vec_t napot [11];
  vec_t tor   [11];
  vec_t rbv   [6];

  always #5 clk = ~clk;

  assign rsp    = {rsp_rdata, rsp_err, rsp_ready};
  assign start0 = start & ~sel;
  assign start1 = start & sel;

  tagger_cfg_seq #(.MAXPARTITION(8), .PATID_WIDTH(4), .READBACK(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start0),
    .addr_cfg_i(addr_cfg), .patid_cfg_i(patid_cfg), .mode_cfg_i(mode_cfg),
    .busy_o(busy0), .done_o(done0), .error_o(error0), .err_idx_o(err_idx0),
    .reg_req_o(req0), .reg_rsp_i(rsp));

  tagger_cfg_seq #(.MAXPARTITION(8), .PATID_WIDTH(4), .READBACK(1'b1)) dut_rb (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start1),
    .addr_cfg_i(addr_cfg), .patid_cfg_i(patid_cfg), .mode_cfg_i(mode_cfg),
    .busy_o(busy1), .done_o(done1), .error_o(error1), .err_idx_o(err_idx1),
    .reg_req_o(req1), .reg_rsp_i(rsp));

  assign req       = sel ? req1 : req0;
  assign v_busy    = sel ? busy1 : busy0;
  assign v_done    = sel ? done1 : done0;
  assign v_error   = sel ? error1 : error0;
  assign v_err_idx = sel ? err_idx1 : err_idx0;
  assign v_addr    = req[69:38];
  assign v_write   = req[37];
  assign v_wdata   = req[36:5];
  assign v_wstrb   = req[4:1];
  assign v_valid   = req[0];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_log(input string nm);
    check({nm, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("%s_addr%0d", nm, i), log_q[i].addr, exp_q[i].addr);
      check($sformatf("%s_wr%0d", nm, i), {31'd0, log_q[i].wr}, {31'd0, exp_q[i].wr});
      if (exp_q[i].wr) check($sformatf("%s_data%0d", nm, i), log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic set_napot();
    addr_cfg  = '0;
    addr_cfg[0*32 +: 32] = 32'h09FFFFFF;
    addr_cfg[1*32 +: 32] = 32'h10FFFFFF;
    addr_cfg[2*32 +: 32] = 32'h19FFFFFF;
    addr_cfg[3*32 +: 32] = 32'h21FFFFFF;
    patid_cfg = 32'h76543210;
    mode_cfg  = 16'h00FF;
  endtask

  task automatic set_tor();
    addr_cfg  = '0;
    addr_cfg[0*32 +: 32] = 32'h08000000;
    addr_cfg[1*32 +: 32] = 32'h10000000;
    addr_cfg[2*32 +: 32] = 32'h18000000;
    addr_cfg[3*32 +: 32] = 32'h20000000;
    patid_cfg = 32'h01234567;
    mode_cfg  = 16'h0055;
  endtask

  // hook: 0 none, 1 restart pulse + input change mid-run, 2 async reset mid-run
  task automatic run_seq(input bit bp, input bit inj_err, input bit corrupt, input int hook);
    int  n;
    int  bpc;
    bit  fin;
    log_q.delete();
    done_cyc = -1; err_cyc = -1; bpc = 0; fin = 0; n = 0; err_at1 = 1'b1;
    @(negedge clk);
    start = 1'b1; rsp_ready = 1'b1; rsp_err = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    while (!fin && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) err_at1 = v_error;
      if (hook == 1 && n == 4) begin
        start = 1'b1;
        addr_cfg = {8{32'hDEADBEEF}};
        patid_cfg = 32'hFFFFFFFF;
        mode_cfg = 16'h0000;
      end
      if (hook == 1 && n == 5) start = 1'b0;
      if (hook == 2 && n == 5) begin
        rst_ni = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, v_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, v_busy}, 32'd0);
        check("rst_mid_error", {31'd0, v_error}, 32'd0);
        fin = 1;
      end else begin
        rsp_ready = 1'b1;
        rsp_err   = 1'b0;
        if (v_valid) begin
          if (bp && v_addr == 32'h24 && bpc < 5) begin
            rsp_ready = 1'b0;
            bpc++;
            check($sformatf("bp_addr%0d", bpc), v_addr, 32'h24);
            check($sformatf("bp_data%0d", bpc), v_wdata, 32'h76543210);
          end else begin
            rsp_err = inj_err && v_write && (v_addr == 32'h28);
            if (v_write) begin
              check("wstrb", {28'd0, v_wstrb}, 32'hF);
              mem[v_addr[5:2]] = v_wdata;
            end else begin
              rsp_rdata = mem[v_addr[5:2]] ^ ((corrupt && v_addr == 32'h0C) ? 32'h1 : 32'h0);
            end
            log_q.push_back('{addr: v_addr, wr: v_write, data: v_wdata});
          end
        end
        if (v_done) begin done_cyc = n; fin = 1; end
        if (v_error) begin err_cyc = n; fin = 1; end
      end
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    napot[0]  = '{32'h04, 1'b1, 32'h09FFFFFF};
    napot[1]  = '{32'h08, 1'b1, 32'h10FFFFFF};
    napot[2]  = '{32'h0C, 1'b1, 32'h19FFFFFF};
    napot[3]  = '{32'h10, 1'b1, 32'h21FFFFFF};
    napot[4]  = '{32'h14, 1'b1, 32'h00000000};
    napot[5]  = '{32'h18, 1'b1, 32'h00000000};
    napot[6]  = '{32'h1C, 1'b1, 32'h00000000};
    napot[7]  = '{32'h20, 1'b1, 32'h00000000};
    napot[8]  = '{32'h24, 1'b1, 32'h76543210};
    napot[9]  = '{32'h28, 1'b1, 32'h000000FF};
    napot[10] = '{32'h00, 1'b1, 32'h00000001};

    tor[0]  = '{32'h04, 1'b1, 32'h08000000};
    tor[1]  = '{32'h08, 1'b1, 32'h10000000};
    tor[2]  = '{32'h0C, 1'b1, 32'h18000000};
    tor[3]  = '{32'h10, 1'b1, 32'h20000000};
    tor[4]  = '{32'h14, 1'b1, 32'h00000000};
    tor[5]  = '{32'h18, 1'b1, 32'h00000000};
    tor[6]  = '{32'h1C, 1'b1, 32'h00000000};
    tor[7]  = '{32'h20, 1'b1, 32'h00000000};
    tor[8]  = '{32'h24, 1'b1, 32'h01234567};
    tor[9]  = '{32'h28, 1'b1, 32'h00000055};
    tor[10] = '{32'h00, 1'b1, 32'h00000001};

    rbv[0] = '{32'h04, 1'b1, 32'h09FFFFFF};
    rbv[1] = '{32'h04, 1'b0, 32'h0};
    rbv[2] = '{32'h08, 1'b1, 32'h10FFFFFF};
    rbv[3] = '{32'h08, 1'b0, 32'h0};
    rbv[4] = '{32'h0C, 1'b1, 32'h19FFFFFF};
    rbv[5] = '{32'h0C, 1'b0, 32'h0};

    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_error", {31'd0, error0}, 32'd0);
    check("rst_err_idx", {24'd0, err_idx0}, 32'd0);
    check("rst_req", req0[31:0], 32'd0);
    check("rst_valid_rb", {31'd0, req1[0]}, 32'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // NAPOT
    set_napot();
    run_seq(1'b0, 1'b0, 1'b0, 0);
    exp_q.delete();
    for (int i = 0; i < 11; i++) exp_q.push_back(napot[i]);
    check_log("napot");
    check("napot_done_cyc", done_cyc, 32'd12);

    // start during the DONE cycle must be ignored
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_in_done_busy", {31'd0, busy0}, 32'd0);
    check("start_in_done_valid", {31'd0, req0[0]}, 32'd0);

    // Backpressure on the PATID write
    run_seq(1'b1, 1'b0, 1'b0, 0);
    check_log("bp");
    check("bp_done_cyc", done_cyc, 32'd17);

    // Slave error on idx 9
    run_seq(1'b0, 1'b1, 1'b0, 0);
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(napot[i]);
    check_log("slverr");
    check("slverr_error", {31'd0, error0}, 32'd1);
    check("slverr_idx", {24'd0, err_idx0}, 32'd9);
    check("slverr_busy", {31'd0, busy0}, 32'd0);
    check("slverr_err_cyc", err_cyc, 32'd11);
    check("slverr_no_done", done_cyc, 32'hFFFFFFFF);

    // TOR (also: error_o cleared by the new start)
    set_tor();
    run_seq(1'b0, 1'b0, 1'b0, 0);
    exp_q.delete();
    for (int i = 0; i < 11; i++) exp_q.push_back(tor[i]);
    check_log("tor");
    check("tor_done_cyc", done_cyc, 32'd12);
    check("err_cleared", {31'd0, err_at1}, 32'd0);

    // Readback with corrupted Addr2 rdata
    set_napot();
    sel = 1'b1;
    run_seq(1'b0, 1'b0, 1'b1, 0);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(rbv[i]);
    check_log("rb");
    check("rb_error", {31'd0, error1}, 32'd1);
    check("rb_idx", {24'd0, err_idx1}, 32'd2);
    check("rb_no_done", done_cyc, 32'hFFFFFFFF);
    sel = 1'b0;

    // Robustness: restart pulse and input change while busy
    set_napot();
    run_seq(1'b0, 1'b0, 1'b0, 1);
    exp_q.delete();
    for (int i = 0; i < 11; i++) exp_q.push_back(napot[i]);
    check_log("robust");
    check("robust_done_cyc", done_cyc, 32'd12);

    // Async reset mid-sequence, then a fresh start
    set_napot();
    run_seq(1'b0, 1'b0, 1'b0, 2);
    @(negedge clk);
    check("rst_hold_valid", {31'd0, req0[0]}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    run_seq(1'b0, 1'b0, 1'b0, 0);
    check_log("after_rst");
    check("after_rst_done_cyc", done_cyc, 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
